// File: rtl/conv3x3_mac_stage.sv
// conv3x3_mac_stage: four 3x3 kernels over a window stream, accumulating per column across input layers.
// Ports: clk/reset_n (async active-low); no_of_input_layers, input_layer_col_size: row-pass shape;
// wt_data/wt_valid/wt_rdy: 4x9 signed kernel bytes, one beat per (row, layer) pass;
// win_data/win_valid/win_rdy/win_layer_id: 9 unsigned pixels per window;
// out_data/out_col/out_valid/out_rdy: 4 accumulated results per column; err: sticky layer-id mismatch.
module conv3x3_mac_stage #(
  parameter int MAX_COLS = 64,
  parameter int ACC_W    = 32,
  parameter int ID_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ID_W-1:0]      no_of_input_layers,
  input  logic [ID_W-1:0]      input_layer_col_size,
  input  logic [287:0]         wt_data,
  input  logic                 wt_valid,
  output logic                 wt_rdy,
  input  logic [71:0]          win_data,
  input  logic                 win_valid,
  output logic                 win_rdy,
  input  logic [ID_W-1:0]      win_layer_id,
  output logic [4*ACC_W-1:0]   out_data,
  output logic [ID_W-1:0]      out_col,
  output logic                 out_valid,
  input  logic                 out_rdy,
  output logic                 err
);
  localparam int CW = $clog2(MAX_COLS);
  typedef enum logic {LOAD_WT, RUN} state_e;
  state_e state_q;
  logic [ID_W-1:0] layer_cnt_q, col_cnt_q, s1_col_q, out_col_q;
  logic signed [7:0] wt_q [4][9];
  logic signed [ACC_W-1:0] acc_q [MAX_COLS][4];
  logic signed [ACC_W-1:0] s1_psum_q [4];
  logic signed [ACC_W-1:0] s1_acc_q [4];
  logic signed [ACC_W-1:0] psum_d [4];
  logic [4*ACC_W-1:0] sum_d, out_data_q;
  logic signed [16:0] prod;
  logic s1_valid_q, s1_last_q, out_valid_q, err_q;
  logic stall, win_acc, col_end, last_layer;
  assign stall      = out_valid_q & ~out_rdy;
  assign wt_rdy     = state_q == LOAD_WT;
  assign win_rdy    = state_q == RUN && !stall;
  assign win_acc    = win_valid & win_rdy;
  assign col_end    = col_cnt_q == input_layer_col_size - ID_W'(1);
  assign last_layer = layer_cnt_q == no_of_input_layers - ID_W'(1);
  assign out_data   = out_data_q;
  assign out_col    = out_col_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;
  always_comb begin
    prod  = '0;
    sum_d = '0;
    for (int k = 0; k < 4; k++) begin
      psum_d[k] = '0;
      for (int t = 0; t < 9; t++) begin
        // zero-extend the unsigned pixel so the product is a 17-bit signed value
        prod      = $signed({1'b0, win_data[71-8*t -: 8]}) * wt_q[k][t];
        psum_d[k] = psum_d[k] + {{(ACC_W-17){prod[16]}}, prod};
      end
      sum_d[4*ACC_W-1-k*ACC_W -: ACC_W] = s1_acc_q[k] + s1_psum_q[k];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD_WT;
      layer_cnt_q <= '0;
      col_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == LOAD_WT && wt_valid) state_q <= RUN;
      if (win_acc) begin
        err_q     <= err_q | (win_layer_id != layer_cnt_q);
        col_cnt_q <= col_end ? '0 : col_cnt_q + ID_W'(1);
        if (col_end) begin
          state_q     <= LOAD_WT;
          layer_cnt_q <= last_layer ? '0 : layer_cnt_q + ID_W'(1);
        end
      end
      if (!stall) begin
        s1_valid_q  <= win_acc;
        out_valid_q <= s1_valid_q & s1_last_q;
        if (win_acc) begin
          s1_col_q  <= col_cnt_q;
          s1_last_q <= last_layer;
        end
        if (s1_valid_q && s1_last_q) begin
          out_data_q <= sum_d;
          out_col_q  <= s1_col_q;
        end
      end
    end
  end
  // kernels, S1 sums and the partial-sum buffer carry no reset: they are always rewritten before use
  always_ff @(posedge clk) begin
    if (wt_valid && wt_rdy)
      for (int k = 0; k < 4; k++)
        for (int t = 0; t < 9; t++)
          wt_q[k][t] <= wt_data[287-72*k-8*t -: 8];
    if (win_acc)
      for (int k = 0; k < 4; k++) begin
        s1_psum_q[k] <= psum_d[k];
        s1_acc_q[k]  <= layer_cnt_q == '0 ? '0 : acc_q[col_cnt_q[CW-1:0]][k];
      end
    if (!stall && s1_valid_q && !s1_last_q)
      for (int k = 0; k < 4; k++)
        acc_q[s1_col_q[CW-1:0]][k] <= sum_d[4*ACC_W-1-k*ACC_W -: ACC_W];
  end
endmodule

// File: tb/tb_conv3x3_mac_stage.sv
// tb_conv3x3_mac_stage: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_conv3x3_mac_stage;
  logic clk = 0, reset_n = 1;
  logic [9:0] no_of_input_layers = 1, input_layer_col_size = 3, win_layer_id = 0, out_col;
  logic [287:0] wt_data = '0;
  logic [71:0] win_data = '0;
  logic [127:0] out_data;
  logic wt_valid = 0, wt_rdy, win_valid = 0, win_rdy, out_valid, out_rdy = 1, err;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [9:0] col; logic [127:0] data; int exp_cyc;} exp_t;
  exp_t sbq[$];
  conv3x3_mac_stage dut (
    .clk(clk), .reset_n(reset_n), .no_of_input_layers(no_of_input_layers),
    .input_layer_col_size(input_layer_col_size), .wt_data(wt_data), .wt_valid(wt_valid),
    .wt_rdy(wt_rdy), .win_data(win_data), .win_valid(win_valid), .win_rdy(win_rdy),
    .win_layer_id(win_layer_id), .out_data(out_data), .out_col(out_col),
    .out_valid(out_valid), .out_rdy(out_rdy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] pk(int a, int b, int c, int d);
    return {a, b, c, d};
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && out_valid && out_rdy) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got col %0d data %h want none", out_col, out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_col", out_col, e.col);
        chk("out_data", out_data, e.data);
        if (e.exp_cyc >= 0) chk("latency", cyc, e.exp_cyc);
      end
    end
  end
  task automatic do_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask
  task automatic send_wt(logic signed [7:0] k0, logic signed [7:0] k1, logic signed [7:0] k2, logic signed [7:0] k3);
    int n = 0;
    wt_data  = {{9{k0}}, {9{k1}}, {9{k2}}, {9{k3}}};
    wt_valid = 1;
    forever begin
      @(negedge clk);
      if (wt_rdy) break;
      if (++n > 100) begin
        chk("wt_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 wt_valid = 0;
  endtask
  task automatic send_win(logic [7:0] pix, logic [9:0] id, logic push, logic [127:0] exp, logic [9:0] col, logic lat);
    int n = 0;
    win_data     = {9{pix}};
    win_layer_id = id;
    win_valid    = 1;
    forever begin
      @(negedge clk);
      if (win_rdy) begin
        if (push) sbq.push_back('{col, exp, lat ? cyc + 2 : -1});
        break;
      end
      if (++n > 100) begin
        chk("win_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 win_valid = 0;
  endtask
  task automatic row(logic [9:0] layer, logic [7:0] pix, logic signed [7:0] k0, logic signed [7:0] k1,
                     logic signed [7:0] k2, logic signed [7:0] k3, logic last, logic [127:0] exp);
    send_wt(k0, k1, k2, k3);
    for (int c = 0; c < int'(input_layer_col_size); c++) send_win(pix, layer, last, exp, 10'(c), 1);
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    // T1: reset values and idle in LOAD_WT
    #1 reset_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_win_rdy", win_rdy, 0);
    chk("rst_wt_rdy", wt_rdy, 1);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_wt_rdy", wt_rdy, 1);
    chk("idle_win_rdy", win_rdy, 0);
    // T2: single layer, 3 columns
    no_of_input_layers = 1;
    input_layer_col_size = 3;
    row(0, 1, 1, -1, 2, 0, 1, pk(9, -9, 18, 0));
    drain();
    // T3: two layers accumulate, weight reload between layers
    do_reset();
    no_of_input_layers = 2;
    input_layer_col_size = 4;
    row(0, 2, 1, 1, 1, 1, 0, '0);
    chk("wt_rdy_between", wt_rdy, 1);
    row(1, 1, 3, 3, 3, 3, 1, pk(45, 45, 45, 45));
    drain();
    // T4: backpressure holds output and blocks windows
    do_reset();
    no_of_input_layers = 1;
    input_layer_col_size = 6;
    send_wt(1, 2, 3, 4);
    out_rdy = 0;
    for (int c = 0; c < 2; c++) send_win(8'(c + 1), 0, 1, pk(9 * (c + 1), 18 * (c + 1), 27 * (c + 1), 36 * (c + 1)), 10'(c), 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_col", out_col, 0);
      chk("hold_data", out_data, pk(9, 18, 27, 36));
      chk("hold_win_rdy", win_rdy, 0);
    end
    @(posedge clk);
    #1 out_rdy = 1;
    for (int c = 2; c < 6; c++) send_win(8'(c + 1), 0, 1, pk(9 * (c + 1), 18 * (c + 1), 27 * (c + 1), 36 * (c + 1)), 10'(c), 0);
    drain();
    // T5: extremes over 16 layers
    do_reset();
    no_of_input_layers = 16;
    input_layer_col_size = 3;
    for (int l = 0; l < 16; l++) row(10'(l), 255, -128, -128, -128, -128, l == 15, pk(-4700160, -4700160, -4700160, -4700160));
    drain();
    // T6: layer-id mismatch is sticky, reset mid-row clears it
    do_reset();
    no_of_input_layers = 1;
    input_layer_col_size = 3;
    send_wt(1, -1, 2, 0);
    chk("err_before", err, 0);
    send_win(1, 1, 1, pk(9, -9, 18, 0), 0, 1);
    repeat (3) @(negedge clk);
    chk("err_set", err, 1);
    @(posedge clk);
    #1;
    send_win(1, 0, 1, pk(9, -9, 18, 0), 1, 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    @(posedge clk);
    #1 reset_n = 0;
    #1;
    chk("err_cleared", err, 0);
    chk("rst2_wt_rdy", wt_rdy, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    row(0, 1, 1, -1, 2, 0, 1, pk(9, -9, 18, 0));
    drain();
    chk("final_err", err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
